// File: rtl/dram_access_ctrl.sv
// Load/store access controller between the datapath memory stage and a
// word-organised data RAM with combinational read data.
//
// Accepts byte-addressed byte/half/word loads and stores. Loads are lane
// extracted and sign/zero extended. Sub-word stores are read-modify-write
// merged into the containing word. Misaligned or illegal-size requests are
// rejected with misalign_err and never touch the RAM.
//
// Ports:
//   clk, rst_n      clock (shared with the RAM), async active-low reset
//   req_*           request handshake and fields (accepted when valid & ready)
//   resp_valid      one-cycle completion pulse
//   resp_rdata      load result, 0 for stores/errors, held until next response
//   misalign_err    qualifies resp_valid: request was rejected
//   mem_we/addr/wdata  RAM write enable, word address, write data
//   mem_rdata       RAM read data (combinational from mem_addr)
module dram_access_ctrl #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              misalign_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StResp} state_e;

  state_e            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;  // only the low half feeds sub-word merges
  logic              err_q, err_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic        req_misaligned;
  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [31:0] lane_data;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    unique case (req_size)
      2'b00:   req_misaligned = 1'b0;
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b1;
    endcase
  end

  assign byte_shift = {addr_q[1:0], 3'b000};
  assign half_shift = {addr_q[1], 4'b0000};

  // Load path: move the addressed lane down to bit 0, then extend.
  assign lane_data = mem_rdata >> byte_shift;

  always_comb begin
    unique case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, lane_data[7:0]}
                                : {{24{lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_val = uns_q ? {16'h0, lane_data[15:0]}
                                : {{16{lane_data[15]}}, lane_data[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  // Store merge: clear the target lane of the old word and OR in new data.
  always_comb begin
    if (size_q == 2'b00) begin
      merged = (mem_rdata & ~(32'h0000_00ff << byte_shift))
             | ({24'h0, wdata_q[7:0]} << byte_shift);
    end else begin
      merged = (mem_rdata & ~(32'h0000_ffff << half_shift))
             | ({16'h0, wdata_q} << half_shift);
    end
  end

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata[15:0];
          err_d   = req_misaligned;
          if (req_misaligned) begin
            resp_rdata_d = 32'h0;
            state_d      = StResp;
          end else if (!req_we) begin
            state_d = StLoad;
          end else if (req_size == 2'b10) begin
            mem_wdata_d = req_wdata;
            state_d     = StWrite;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad: begin
        resp_rdata_d = load_val;
        state_d      = StResp;
      end
      StRmwRd: begin
        mem_wdata_d = merged;
        state_d     = StWrite;
      end
      StWrite: begin
        resp_rdata_d = 32'h0;
        state_d      = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 16'h0;
      err_q        <= 1'b0;
      mem_wdata_q  <= 32'h0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Decoded straight from the state register: glitch-free, and it falls
  // with the asynchronous reset so an interrupted store never commits.
  assign mem_we       = (state_q == StWrite);
  assign req_ready    = (state_q == StIdle);
  assign resp_valid   = (state_q == StResp);
  assign misalign_err = resp_valid & err_q;
  assign mem_addr     = addr_q[ADDR_W+1:2];
  assign mem_wdata    = mem_wdata_q;
  assign resp_rdata   = resp_rdata_q;

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Self-checking bench for dram_access_ctrl: drives the controller against a
// behavioural 32x32 RAM and compares against a byte-array reference model.
module tb_dram_access_ctrl;

  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              misalign_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dram_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .misalign_err (misalign_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Behavioural data RAM: combinational read, write on rising edge.
  logic [31:0] ram [32];
  logic        ram_init = 1'b1;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 32; i++) ram[i] <= 32'haaaa_aaaa;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = ram[mem_addr];

  // Reference model: plain byte-addressed memory.
  logic [7:0] mdl [128];

  function automatic logic [31:0] mdl_word(input int w);
    return {mdl[4*w+3], mdl[4*w+2], mdl[4*w+1], mdl[4*w]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "/resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "/resp_rdata"}, resp_rdata, 32'h0);
    check({tag, "/misalign_err"}, 32'(misalign_err), 32'd0);
    check({tag, "/mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "/mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "/mem_wdata"}, mem_wdata, 32'h0);
  endtask

  // One full request: predicts the outcome from the model, drives it, and
  // checks latency, write count, response fields and the RAM word.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [6:0] addr, input logic [31:0] wdata);
    logic        mis;
    logic [31:0] exp_rd;
    logic [7:0]  b;
    logic [15:0] h;
    int          exp_lat, exp_wr, lat, wr;
    logic        got, er;
    logic [31:0] rd;

    mis    = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 0);
    exp_rd = 32'h0;
    exp_wr = 0;
    if (mis) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 2;
      b = mdl[int'(addr)];
      h = {mdl[int'(addr) + 1], mdl[int'(addr)]};
      if (size == 2'd0)      exp_rd = uns ? {24'h0, b} : {{24{b[7]}}, b};
      else if (size == 2'd1) exp_rd = uns ? {16'h0, h} : {{16{h[15]}}, h};
      else                   exp_rd = mdl_word(int'(addr) / 4);
    end else begin
      exp_wr  = 1;
      exp_lat = (size == 2'd2) ? 2 : 3;
      for (int i = 0; i < (1 << size); i++) mdl[int'(addr) + i] = wdata[8*i +: 8];
    end

    @(negedge clk);
    check({tag, "/ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_wdata    = $urandom;
    req_addr     = 7'($urandom);

    got = 1'b0;
    lat = 0;
    wr  = 0;
    rd  = 32'h0;
    er  = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_we) wr++;
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
        rd  = resp_rdata;
        er  = misalign_err;
      end
    end
    check({tag, "/resp_seen"}, 32'(got), 32'd1);
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/writes"}, 32'(wr), 32'(exp_wr));
    check({tag, "/rdata"}, rd, exp_rd);
    check({tag, "/err"}, 32'(er), 32'(mis));

    @(negedge clk);
    check({tag, "/pulse"}, 32'(resp_valid), 32'd0);
    check({tag, "/held"}, resp_rdata, exp_rd);
    check({tag, "/ram"}, ram[addr[6:2]], mdl_word(int'(addr) / 4));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mdl[i] = 8'haa;

    // Power-on reset with RAM preset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Word store then load.
    do_req("sw08", 1'b1, 2'd2, 1'b0, 7'h08, 32'h1234_5678);
    check("sw08/word2", ram[2], 32'h1234_5678);
    do_req("lw08", 1'b0, 2'd2, 1'b0, 7'h08, 32'h0);

    // Reset mid-run clears the held load result.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    // Byte store merge (upper store bits are don't-care) and byte loads.
    do_req("sb05", 1'b1, 2'd0, 1'b0, 7'h05, 32'hffff_ff5a);
    check("sb05/word1", ram[1], 32'haaaa_5aaa);
    do_req("lb05", 1'b0, 2'd0, 1'b0, 7'h05, 32'h0);
    do_req("lb04", 1'b0, 2'd0, 1'b0, 7'h04, 32'h0);
    do_req("lbu04", 1'b0, 2'd0, 1'b1, 7'h04, 32'h0);

    // Half accesses.
    do_req("sh0e", 1'b1, 2'd1, 1'b0, 7'h0e, 32'h1234_8001);
    check("sh0e/word3", ram[3], 32'h8001_aaaa);
    do_req("lh0e", 1'b0, 2'd1, 1'b0, 7'h0e, 32'h0);
    do_req("lhu0e", 1'b0, 2'd1, 1'b1, 7'h0e, 32'h0);

    // Misaligned and illegal-size requests.
    do_req("lh03", 1'b0, 2'd1, 1'b0, 7'h03, 32'h0);
    do_req("sw06", 1'b1, 2'd2, 1'b0, 7'h06, 32'hcafe_f00d);
    do_req("sz11", 1'b1, 2'd3, 1'b0, 7'h0c, 32'h0bad_0bad);

    // Reset during WRITE: the store must not commit nor respond.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = 7'h10;
    req_wdata = 32'hdead_beef;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstwr/we_in_write", 32'(mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstwr/we_async_drop", 32'(mem_we), 32'd0);
    check("rstwr/ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstwr/no_resp", 32'(resp_valid), 32'd0);
    end
    check("rstwr/word4", ram[4], 32'haaaa_aaaa);
    do_req("lw10", 1'b0, 2'd2, 1'b0, 7'h10, 32'h0);

    // Randomised traffic, mostly aligned with some misaligned/illegal.
    for (int n = 0; n < 150; n++) begin
      logic [1:0] sz;
      logic [6:0] ad;
      sz = 2'($urandom_range(0, 3));
      ad = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) ad = ad & ~7'((1 << sz) - 1);
      do_req("rnd", 1'($urandom), sz, 1'($urandom), ad, $urandom);
    end

    for (int w = 0; w < 32; w++) check("final_ram", ram[w], mdl_word(w));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dram_access_ctrl.md
Name: dram_access_ctrl

Overview:
Load/store access controller between the single-cycle datapath's memory stage and the 32x32 word data RAM (dram_IP). It accepts byte-addressed load/store requests of size byte, half or word. It does sign/zero extension for loads and read-modify-write merging for sub-word stores, and flags misaligned accesses. It drives the RAM's write enable, word address and write data, and consumes its combinational read data.

Parameters:
ADDR_W, 5, word-address width of the RAM; the byte address is ADDR_W+2 bits.

Ports:
clk  input  1  rising-edge clock, shared with the RAM
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  ADDR_W+2  byte address
req_wdata  input  32  store data; byte and half stores use the low bits
resp_valid  output  1  one-cycle pulse when the request completes
resp_rdata  output  32  load result; 0 for stores and errors; held until the next response
misalign_err  output  1  valid with resp_valid; 1 = request rejected
mem_we  output  1  to RAM MemWR
mem_addr  output  ADDR_W  to RAM addr, equal to req_addr[ADDR_W+1:2] of the latched request
mem_wdata  output  32  to RAM writedata
mem_rdata  input  32  from RAM readdata (combinational)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All registers 0: req_ready=1, resp_valid=0, resp_rdata=0, misalign_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Byte lanes are little-endian:
  - byte k (addr[1:0]=k) occupies bits [8k+7:8k];
  - half h (addr[1]=h) occupies bits [16h+15:16h].
- Acceptance:
  - A request is accepted on a rising edge with req_valid=1 and req_ready=1.
  - On acceptance the controller latches all req_* fields.
  - Inputs are ignored outside IDLE.
- Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - The state goes to RESP with the error flag set and no RAM access.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
  - IDLE: if accepted and misaligned -> RESP (error). Else if load -> LOAD. Else if word store -> WRITE. Else sub-word store -> RMW_RD.
  - LOAD: mem_addr drives the latched word address. At the edge, capture the extracted and extended lane of mem_rdata into resp_rdata. -> RESP.
  - RMW_RD: at the edge, register mem_wdata = mem_rdata with the target lane replaced by req_wdata[7:0] or [15:0]. -> WRITE.
  - WRITE: mem_we=1, decoded from the registered state so it is glitch-free. For a word store, mem_wdata = req_wdata. The RAM commits at the closing edge. -> RESP.
  - RESP: resp_valid=1 for exactly one cycle. misalign_err=1 only for errors. resp_rdata=0 for stores and errors. -> IDLE.
- Latency from the acceptance edge to the resp_valid cycle:
  - load 2 cycles;
  - word store 2;
  - sub-word store 3;
  - error 1.
- req_ready is high only in IDLE. Back-to-back requests therefore cost latency+1 cycles each.
- mem_we is 0 in every state except WRITE. Exactly one write per store, none per load or error.
- The response has no backpressure: resp_valid is a pulse and the consumer must sample it.
- Reset mid-operation:
  - Any state returns to IDLE immediately and mem_we drops asynchronously.
  - A store whose WRITE-closing edge occurs while rst_n=0 is not committed.
  - The aborted request produces no response.
- Store data wider than the size is ignored: upper bits are don't-care for byte and half.

Test Plan:
- Reset values (RAM preset 0xAAAAAAAA): assert rst_n=0 mid-run -> all outputs at reset values, req_ready=1.
- Word store then load: sw 0x12345678 @0x08, then lw @0x08 -> resp_rdata=0x12345678. Store latency is 2 cycles and mem_we was high exactly one cycle.
- Byte store merge: sb 0x5A @0x05 -> word 1 = 0xAAAA5AAA.
  - lb @0x05 -> 0x0000005A.
  - lb @0x04 -> 0xFFFFFFAA.
  - lbu @0x04 -> 0x000000AA.
  - Store latency is 3 cycles.
- Half accesses: sh 0x8001 @0x0E -> word 3 = 0x8001AAAA.
  - lh @0x0E -> 0xFFFF8001.
  - lhu @0x0E -> 0x00008001.
- Misalignment: lh @0x03, sw @0x06, and size=11 -> one-cycle resp_valid with misalign_err=1, resp_rdata=0, mem_we never asserted, RAM unchanged.
- Reset during WRITE: sw 0xDEADBEEF @0x10, drop rst_n in the WRITE cycle before the edge -> no resp_valid, word 4 stays 0xAAAAAAAA, next request accepted normally.
